// File: rtl/serial_in_parallel_out_dynamic.sv
// Collects a variable-length burst of width_p words into one max_els_p*width_p parallel word.
// The length arrives with the first word; the result is handed off with valid/yumi, single-buffered.
module serial_in_parallel_out_dynamic #(
  parameter int width_p       = 64,
  parameter int max_els_p     = 8,
  parameter int lg_max_els_lp = (max_els_p > 1) ? $clog2(max_els_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  input  logic [width_p-1:0]             data_i,
  input  logic [lg_max_els_lp-1:0]       len_i,
  output logic                           ready_o,
  output logic                           len_ready_o,
  output logic                           v_o,
  output logic [max_els_p*width_p-1:0]   data_o,
  input  logic                           yumi_i
);

  localparam logic [lg_max_els_lp-1:0] max_len_lp = lg_max_els_lp'(max_els_p - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [lg_max_els_lp-1:0] cnt_q, cnt_d;
  logic [lg_max_els_lp-1:0] len_q, len_d;
  logic [width_p-1:0]       slots_q [max_els_p];
  logic [width_p-1:0]       slots_d [max_els_p];
  logic [lg_max_els_lp-1:0] eff_len;
  logic                     first_word;

  assign ready_o     = (state_q == ST_FILL);
  assign len_ready_o = ready_o & (cnt_q == '0);
  assign v_o         = (state_q == ST_FULL);
  assign first_word  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    slots_d = slots_q;
    eff_len = len_q;

    case (state_q)
      ST_FILL: begin
        if (v_i) begin
          // The length only counts on the first word; later len_i values are ignored.
          if (first_word) begin
            if (int'(len_i) > max_els_p - 1) begin
              eff_len = max_len_lp;
            end else begin
              eff_len = len_i;
            end
            len_d = eff_len;
          end

          for (int i = 0; i < max_els_p; i++) begin
            if (i == int'(cnt_q)) begin
              slots_d[i] = data_i;
            end else if (first_word) begin
              slots_d[i] = '0;
            end
          end

          if (cnt_q == eff_len) begin
            state_d = ST_FULL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + lg_max_els_lp'(1);
          end
        end
      end

      ST_FULL: begin
        if (yumi_i) begin
          state_d = ST_FILL;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_comb begin
    data_o = '0;
    for (int i = 0; i < max_els_p; i++) begin
      data_o[i*width_p +: width_p] = slots_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      len_q   <= '0;
      slots_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      slots_q <= slots_d;
    end
  end

endmodule

// File: tb/tb_serial_in_parallel_out_dynamic.sv
// Directed bench for serial_in_parallel_out_dynamic: vector table plus hand-written reset,
// backpressure and length-clamp sequences.
module tb_serial_in_parallel_out_dynamic;

  localparam int W  = 64;
  localparam int N  = 8;
  localparam int LG = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            v_i, yumi_i, ready_o, len_ready_o, v_o;
  logic [W-1:0]    data_i;
  logic [LG-1:0]   len_i;
  logic [N*W-1:0]  data_o;

  logic            vb, yumib, rdyb, lrdyb, vob;
  logic [7:0]      datb;
  logic [2:0]      lenb;
  logic [31:0]     datob;

  serial_in_parallel_out_dynamic #(.width_p(W), .max_els_p(N)) dut (
    .clk_i(clk), .reset_i(rst_n), .v_i(v_i), .data_i(data_i), .len_i(len_i),
    .ready_o(ready_o), .len_ready_o(len_ready_o), .v_o(v_o), .data_o(data_o),
    .yumi_i(yumi_i)
  );

  serial_in_parallel_out_dynamic #(.width_p(8), .max_els_p(4), .lg_max_els_lp(3)) dut_b (
    .clk_i(clk), .reset_i(rst_n), .v_i(vb), .data_i(datb), .len_i(lenb),
    .ready_o(rdyb), .len_ready_o(lrdyb), .v_o(vob), .data_o(datob),
    .yumi_i(yumib)
  );

  typedef struct {
    logic         v;
    logic [63:0]  d;
    logic [2:0]   len;
    logic         yumi;
    logic         e_v;
    logic         e_rdy;
    logic         e_lrdy;
    logic         chk_d;
    logic [511:0] e_d;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic v, input logic [63:0] d, input logic [2:0] len,
                              input logic yumi, input logic e_v, input logic e_rdy,
                              input logic e_lrdy, input logic chk_d, input logic [511:0] e_d);
    vec_t r;
    r.v = v; r.d = d; r.len = len; r.yumi = yumi;
    r.e_v = e_v; r.e_rdy = e_rdy; r.e_lrdy = e_lrdy; r.chk_d = chk_d; r.e_d = e_d;
    return r;
  endfunction

  function automatic logic [511:0] wset(input logic [511:0] cur, input int idx,
                                        input logic [63:0] w);
    logic [511:0] r;
    r = cur;
    r[idx*64 +: 64] = w;
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [511:0] exp;

    rst_n = 1'b0;
    v_i = 1'b0; data_i = '0; len_i = '0; yumi_i = 1'b0;
    vb = 1'b0; datb = '0; lenb = '0; yumib = 1'b0;

    // Full-length burst, then short message to show stale slots are cleared.
    exp = '0;
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(1'b1, 64'(16 + i), 3'd7, 1'b0, 1'b0, 1'b1, (i == 0), 1'b0, '0));
      exp = wset(exp, i, 64'(16 + i));
    end
    tbl.push_back(mk(1'b0, 64'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp));
    tbl.push_back(mk(1'b0, 64'h0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, exp));
    tbl.push_back(mk(1'b1, 64'hA0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0));
    tbl.push_back(mk(1'b1, 64'hA1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0));
    exp = wset(wset('0, 0, 64'hA0), 1, 64'hA1);
    tbl.push_back(mk(1'b0, 64'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp));
    tbl.push_back(mk(1'b0, 64'h0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0));
    // len_i drops to 0 after the first word, with spurious yumi mid-message.
    tbl.push_back(mk(1'b1, 64'h30, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0));
    tbl.push_back(mk(1'b1, 64'h31, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b1, 64'h32, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b1, 64'h33, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0));
    exp = wset(wset(wset(wset('0, 0, 64'h30), 1, 64'h31), 2, 64'h32), 3, 64'h33);
    tbl.push_back(mk(1'b0, 64'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp));
    tbl.push_back(mk(1'b0, 64'h0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0));
    // Single-word messages: held v_i during the yumi cycle must not be taken.
    tbl.push_back(mk(1'b1, 64'h55, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0));
    tbl.push_back(mk(1'b1, 64'h66, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, wset('0, 0, 64'h55)));
    tbl.push_back(mk(1'b1, 64'h66, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0));
    tbl.push_back(mk(1'b0, 64'h0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, wset('0, 0, 64'h66)));
    tbl.push_back(mk(1'b0, 64'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0));

    // Reset state.
    tick();
    chk("rst_v_o", 512'(v_o), 512'(1'b0));
    chk("rst_ready_o", 512'(ready_o), 512'(1'b1));
    chk("rst_len_ready_o", 512'(len_ready_o), 512'(1'b1));
    chk("rst_data_o", data_o, '0);
    #2 rst_n = 1'b1;
    tick();

    // Table-driven vectors.
    foreach (tbl[k]) begin
      v_i = tbl[k].v; data_i = tbl[k].d; len_i = tbl[k].len; yumi_i = tbl[k].yumi;
      chk($sformatf("vec%0d_v_o", k), 512'(v_o), 512'(tbl[k].e_v));
      chk($sformatf("vec%0d_ready_o", k), 512'(ready_o), 512'(tbl[k].e_rdy));
      chk($sformatf("vec%0d_len_ready_o", k), 512'(len_ready_o), 512'(tbl[k].e_lrdy));
      if (tbl[k].chk_d) chk($sformatf("vec%0d_data_o", k), data_o, tbl[k].e_d);
      tick();
    end
    v_i = 1'b0; yumi_i = 1'b0;

    // Backpressure: two-word message, then hold the next word while the consumer stalls.
    v_i = 1'b1; len_i = 3'd1; data_i = 64'h70; tick();
    data_i = 64'h71; tick();
    exp = wset(wset('0, 0, 64'h70), 1, 64'h71);
    data_i = 64'h80; len_i = 3'd0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_v_o", c), 512'(v_o), 512'(1'b1));
      chk($sformatf("bp%0d_ready_o", c), 512'(ready_o), 512'(1'b0));
      chk($sformatf("bp%0d_data_o", c), data_o, exp);
      tick();
    end
    yumi_i = 1'b1;
    chk("bp_yumi_ready_o", 512'(ready_o), 512'(1'b0));
    tick();
    yumi_i = 1'b0;
    chk("bp_after_v_o", 512'(v_o), 512'(1'b0));
    chk("bp_after_len_ready_o", 512'(len_ready_o), 512'(1'b1));
    tick();
    v_i = 1'b0;
    chk("bp_pending_v_o", 512'(v_o), 512'(1'b1));
    chk("bp_pending_data_o", data_o, wset('0, 0, 64'h80));
    yumi_i = 1'b1; tick();
    yumi_i = 1'b0;

    // Asynchronous reset in the middle of a four-word message.
    v_i = 1'b1; len_i = 3'd3; data_i = 64'h01; tick();
    data_i = 64'h02; tick();
    v_i = 1'b0;
    chk("mid_len_ready_o", 512'(len_ready_o), 512'(1'b0));
    #3 rst_n = 1'b0;
    #1;
    chk("arst_v_o", 512'(v_o), 512'(1'b0));
    chk("arst_ready_o", 512'(ready_o), 512'(1'b1));
    chk("arst_len_ready_o", 512'(len_ready_o), 512'(1'b1));
    chk("arst_data_o", data_o, '0);
    #2 rst_n = 1'b1;
    v_i = 1'b1; len_i = 3'd0; data_i = 64'hAA;
    tick();
    v_i = 1'b0;
    chk("post_rst_v_o", 512'(v_o), 512'(1'b1));
    chk("post_rst_data_o", data_o, wset('0, 0, 64'hAA));
    yumi_i = 1'b1; tick();
    yumi_i = 1'b0;

    // Clamp: max_els_p=4 with len_i=6 collects exactly four words.
    vb = 1'b1; lenb = 3'd6;
    for (int i = 0; i < 4; i++) begin
      datb = 8'(8'hB0 + i);
      chk($sformatf("clamp_w%0d_v_o", i), 512'(vob), 512'(1'b0));
      chk($sformatf("clamp_w%0d_ready_o", i), 512'(rdyb), 512'(1'b1));
      tick();
    end
    vb = 1'b0;
    chk("clamp_v_o", 512'(vob), 512'(1'b1));
    chk("clamp_data_o", 512'(datob), 512'(32'hB3B2B1B0));
    chk("clamp_len_ready_o", 512'(lrdyb), 512'(1'b0));
    yumib = 1'b1; tick();
    yumib = 1'b0;
    chk("clamp_after_ready_o", 512'(rdyb), 512'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_in_parallel_out_dynamic.md
# serial_in_parallel_out_dynamic

Gathers a variable-length burst of narrow words into one wide parallel word for stream-to-lite protocol conversion in the memory-side network. The burst length is supplied with the first word of each message and held in an internal single-entry length register, which behaves as a one-element FIFO. The parallel word is presented with a valid/yumi handshake. The block is single-buffered: one message is assembled, handed off and dequeued before the next message may start.

## Interface
- `width_p`, default 64: width of each serial input word.
- `max_els_p`, default 8: maximum words per message; must be ≥ 1.
- `lg_max_els_lp`, derived as safe clog2(`max_els_p`), minimum 1: width of the length field.

Ports:
- `clk_i`  in  1: single clock; all state updates on its rising edge.
- `reset_i`  in  1: reset, asynchronous, active-low; asserted (0) clears all state immediately.
- `v_i`  in  1: input word valid.
- `data_i`  in  `width_p`: input word.
- `len_i`  in  `lg_max_els_lp`: word count minus 1; sampled only on the first word of a message.
- `ready_o`  out  1: block can accept a word; a word transfers when `v_i & ready_o`.
- `len_ready_o`  out  1: next accepted word is the first of a message (`len_i` will be sampled).
- `v_o`  out  1: assembled parallel word valid.
- `data_o`  out  `max_els_p*width_p`: parallel word; word i is at bits [i*`width_p` +: `width_p`].
- `yumi_i`  in  1: consumer takes `data_o`; legal only while `v_o`=1.

## Operation
State:
- `cnt`: words received so far, 0..`max_els_p`-1.
- `len_r`: latched length; a one-entry holding register.
- `full`: drives `v_o`.
- `buf`: `max_els_p` words of `width_p` bits.

Output equations:
- `ready_o` = ~`full`.
- `len_ready_o` = ~`full` & (`cnt`==0).

On each accepted word (`v_i & ready_o`):
- Effective length `L`:
  - If `cnt`==0: `L` = min(`len_i`, `max_els_p`-1). Values of `len_i` above `max_els_p`-1 are clamped to that value. `len_r` ← `L`.
  - Otherwise: `L` = `len_r`.
- `buf[cnt]` ← `data_i`.
- First word (`cnt`==0) only: slots 1..`max_els_p`-1 are cleared to 0, so unused upper slots of `data_o` read zero.
- If `cnt`==`L`: `full` ← 1 and `cnt` ← 0 (message complete).
- Otherwise: `cnt` ← `cnt`+1.

Handoff:
- `data_o` = `buf` at all times.
- When `yumi_i` and `full`: `full` ← 0.
- `yumi_i` while `full`=0 is ignored: no state change.
- `len_i` is ignored on non-first words; changing it mid-message has no effect.

Reset (`reset_i`=0, asynchronous):
- `cnt`=0, `len_r`=0, `full`=0, `buf`=0.
- Outputs: `v_o`=0, `data_o`=0, `ready_o`=1, `len_ready_o`=1.
- A partially received message is discarded.
- Release of reset takes effect on the next `clk_i` edge.

## Timing
- `ready_o` and `len_ready_o` depend only on registered state, with no combinational path from `v_i` or `yumi_i`.
- `v_o` rises in the cycle after the last word of a message is accepted.
- While `v_o`=1, `ready_o`=0, so no input is accepted, including in the yumi cycle.
- After `yumi_i`, `v_o`=0 and `ready_o`=1 from the next cycle.
- Throughput:
  - Single-word messages (`len_i`=0): at most one message per 2 cycles with a consumer that yumis immediately.
  - N-word message: N+1 cycles per message.
- Back-to-back input words within a message are accepted every cycle, with no bubbles.
- Holding `v_i`=1 while `ready_o`=0 is legal and transfers nothing.
- After a message completes, the next message's first word waits until the cycle after `yumi_i`.

## Test plan
- **Reset:** drive `reset_i`=0 mid-message (2 of 4 words received), asynchronously between clock edges.
  - Required: `v_o`=0, `ready_o`=1, `len_ready_o`=1 and `data_o`=0 immediately.
  - After release: a fresh message with `len_i`=0 and `data_i`=0xAA yields `data_o` word0=0xAA, all other words 0.
- **Full-length burst:** `width_p`=64, `max_els_p`=8, `len_i`=7, words 0x10..0x17 on consecutive cycles.
  - Required: `len_ready_o`=1 only on the first word.
  - `v_o`=1 in the cycle after word 0x17, with `data_o` word i = 0x10+i.
  - `ready_o`=0 until the cycle after `yumi_i`.
- **Short after long:** after the 8-word message, send `len_i`=1 with words 0xA0, 0xA1.
  - Required: `data_o` = {0, …, 0, 0xA1, 0xA0}, i.e. stale slots cleared.
- **Backpressure:** complete a message, hold `yumi_i`=0 for 5 cycles while `v_i`=1 with the next word.
  - Required: `data_o` stable, `ready_o`=0 and no word accepted.
  - After yumi, the pending word is accepted on the first cycle `ready_o`=1.
- **Length rules:**
  - `len_i` changes from 3 to 0 after the first word: required 4 words are still collected.
  - `max_els_p`=4 with `len_i` encoding above 3: required clamped to 4 words.
- **Spurious yumi:** `yumi_i`=1 while `v_o`=0 mid-message.
  - Required: no state change; the message completes normally.
